// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified memory port: arbiter states, grant encoding and the
// latched request payload.
package riscv_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_BE_W   = MEM_DATA_W / 8;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  we;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/resp_timeout_ctr.sv
// Counts cycles spent waiting for a memory response; flags the last allowed cycle.
module resp_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: round-robin on ties,
// one outstanding transaction, and a timeout error response if memory never answers.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_we,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                grant_sel
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t        r_state;
  logic              r_last_grant;
  logic              r_grant;
  mem_req_t          r_req;
  logic              r_mem_req_valid;
  logic              r_if_resp_valid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_if_err;
  logic              r_ls_resp_valid;
  logic [DATA_W-1:0] r_ls_rdata;
  logic              r_ls_err;

  logic              w_any_req;
  logic              w_pick_ls;
  logic              w_accept;
  logic              w_mem_accept;
  logic              w_resp_done;
  logic              w_resp_err;
  logic [DATA_W-1:0] w_resp_rdata;
  logic              w_expired;
  mem_req_t          w_next_req;

  // Arbitration, request formatting and handshake decode.
  always_comb begin
    w_any_req    = if_req_valid || ls_req_valid;
    w_pick_ls    = ls_req_valid && (!if_req_valid || (r_last_grant == GRANT_IF));
    w_accept     = (r_state == IDLE) && !rst && w_any_req;
    if_req_ready = w_accept && !w_pick_ls;
    ls_req_ready = w_accept && w_pick_ls;
    w_next_req   = '0;
    if (w_pick_ls) begin
      w_next_req.addr  = MEM_ADDR_W'(ls_addr);
      w_next_req.we    = ls_we;
      w_next_req.wdata = MEM_DATA_W'(ls_wdata);
      w_next_req.be    = MEM_BE_W'(ls_be);
    end else begin
      w_next_req.addr = MEM_ADDR_W'(if_addr);
      w_next_req.be   = '1;
    end
    w_mem_accept = (r_state == REQ) && mem_req_ready;
    // A response arriving on the last allowed cycle still beats the timeout.
    w_resp_done  = (r_state == WAIT) && (mem_resp_valid || w_expired);
    w_resp_err   = !mem_resp_valid;
    w_resp_rdata = mem_resp_valid ? mem_rdata : '0;
  end

  resp_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_mem_accept),
    .i_enable  (r_state == WAIT),
    .o_expired (w_expired)
  );

  // State, latched request and registered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_last_grant    <= GRANT_IF;
      r_grant         <= GRANT_IF;
      r_req           <= '0;
      r_mem_req_valid <= 1'b0;
      r_if_resp_valid <= 1'b0;
      r_if_rdata      <= '0;
      r_if_err        <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      r_ls_rdata      <= '0;
      r_ls_err        <= 1'b0;
    end else begin
      r_if_resp_valid <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req           <= w_next_req;
            r_grant         <= w_pick_ls;
            r_last_grant    <= w_pick_ls;
            r_mem_req_valid <= 1'b1;
            r_state         <= REQ;
          end
        end
        REQ: begin
          if (w_mem_accept) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          if (w_resp_done) begin
            if (r_grant == GRANT_LS) begin
              r_ls_resp_valid <= 1'b1;
              r_ls_rdata      <= w_resp_rdata;
              r_ls_err        <= w_resp_err;
            end else begin
              r_if_resp_valid <= 1'b1;
              r_if_rdata      <= w_resp_rdata;
              r_if_err        <= w_resp_err;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = ADDR_W'(r_req.addr);
  assign mem_we        = r_req.we;
  assign mem_wdata     = DATA_W'(r_req.wdata);
  assign mem_be        = BE_W'(r_req.be);
  assign grant_sel     = r_grant;
  assign if_resp_valid = r_if_resp_valid;
  assign if_rdata      = r_if_rdata;
  assign if_err        = r_if_err;
  assign ls_resp_valid = r_ls_resp_valid;
  assign ls_rdata      = r_ls_rdata;
  assign ls_err        = r_ls_err;

endmodule
